// File: rtl/simple_axi_cmd_sequencer_pkg.sv
// rtl/simple_axi_cmd_sequencer_pkg.sv - shared codes for the command sequencer
// Contents: master i_rw codes, transfer size codes, response status codes,
//           sequencer FSM state encodings, command legality helper.
package simple_axi_cmd_sequencer_pkg;

  // Master i_rw encoding
  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  // Transfer size: bytes = 1 << size
  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  // Response status
  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_ERROR   = 2'b01;
  localparam logic [1:0] STAT_INVALID = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  // Sequencer FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // A command is illegal when its size code is unknown or its address is
  // not naturally aligned to the transfer size. Only the low three address
  // bits can matter, since the largest transfer is eight bytes.
  function automatic logic cmd_illegal(input logic [2:0] size, input logic [2:0] addr_lo);
    case (size)
      SIZE_BYTE:  return 1'b0;
      SIZE_HALF:  return addr_lo[0];
      SIZE_WORD:  return |addr_lo[1:0];
      SIZE_DWORD: return |addr_lo[2:0];
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/simple_axi_sync_fifo.sv
// rtl/simple_axi_sync_fifo.sv - synchronous FIFO with flop storage and show-ahead head
// Ports: clk/rst (async, active-high); push/din write side; pop/dout read side,
//        dout always presents the oldest entry; full/empty/count status.
module simple_axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/simple_axi_cmd_sequencer.sv
// rtl/simple_axi_cmd_sequencer.sv - buffered command front-end for simple_axi_master
// Ports: i_clk/i_rst (async, active-high)
//        s_cmd_*  : command input (valid/ready), read/size/addr/wdata/tag
//        m_rsp_*  : response output (valid/ready), rdata/tag/status
//        o_rw/o_size/o_addr/o_wdata/o_clear : drive to the master
//        i_rdata/i_wait/i_done/i_error/i_invalid : status from the master
//        o_busy   : work pending or in progress
module simple_axi_cmd_sequencer
  import simple_axi_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             s_cmd_valid,
  output logic             s_cmd_ready,
  input  logic             s_cmd_read,
  input  logic [2:0]       s_cmd_size,
  input  logic [31:0]      s_cmd_addr,
  input  logic [63:0]      s_cmd_wdata,
  input  logic [TAG_W-1:0] s_cmd_tag,
  output logic             m_rsp_valid,
  input  logic             m_rsp_ready,
  output logic [63:0]      m_rsp_rdata,
  output logic [TAG_W-1:0] m_rsp_tag,
  output logic [1:0]       m_rsp_status,
  output logic [2:0]       o_size,
  output logic [31:0]      o_addr,
  output logic [63:0]      o_wdata,
  output logic [1:0]       o_rw,
  output logic             o_clear,
  input  logic [63:0]      i_rdata,
  input  logic             i_wait,
  input  logic             i_done,
  input  logic             i_error,
  input  logic             i_invalid,
  output logic             o_busy
);

  localparam int ENTRY_W = 1 + 3 + 32 + 64 + TAG_W;
  localparam int CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]             state;
  logic [CNT_W-1:0]       tmo_cnt;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [ENTRY_W-1:0]     head;

  logic                   head_read;
  logic [2:0]             head_size;
  logic [31:0]            head_addr;
  logic [63:0]            head_wdata;
  logic [TAG_W-1:0]       head_tag;
  logic                   head_bad;
  logic                   start;
  logic                   flag;

  assign s_cmd_ready = ~fifo_full;
  assign fifo_push   = s_cmd_valid & s_cmd_ready;

  simple_axi_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .din   ({s_cmd_read, s_cmd_size, s_cmd_addr, s_cmd_wdata, s_cmd_tag}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_read  = head[ENTRY_W-1];
  assign head_size  = head[ENTRY_W-2 -: 3];
  assign head_addr  = head[ENTRY_W-5 -: 32];
  assign head_wdata = head[TAG_W+63 -: 64];
  assign head_tag   = head[TAG_W-1:0];
  assign head_bad   = cmd_illegal(head_size, head_addr[2:0]);

  // A new command is only taken while the master is not still busy.
  assign start = (state == ST_IDLE) & ~fifo_empty & ~i_wait;
  assign flag  = i_done | i_error | i_invalid;

  // The head entry stays in the FIFO for the whole transfer so its tag and
  // direction are available at completion; it leaves on CLEAR, or right
  // away when rejected locally.
  assign fifo_pop = (start & head_bad) | (state == ST_CLEAR);

  assign o_busy = (state != ST_IDLE) | (fifo_count != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      o_rw         <= RW_IDLE;
      o_size       <= '0;
      o_addr       <= '0;
      o_wdata      <= '0;
      o_clear      <= 1'b0;
      m_rsp_valid  <= 1'b0;
      m_rsp_rdata  <= '0;
      m_rsp_tag    <= '0;
      m_rsp_status <= STAT_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (head_bad) begin
              // Rejected without ever touching the master.
              m_rsp_status <= STAT_INVALID;
              m_rsp_rdata  <= '0;
              m_rsp_tag    <= head_tag;
              m_rsp_valid  <= 1'b1;
              state        <= ST_RESP;
            end else begin
              o_rw    <= head_read ? RW_READ : RW_WRITE;
              o_size  <= head_size;
              o_addr  <= head_addr;
              o_wdata <= head_wdata;
              state   <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          // A master that completes without ever raising i_wait is also
          // treated as having accepted the request.
          if (i_wait | flag) begin
            o_rw    <= RW_IDLE;
            tmo_cnt <= '0;
            state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (flag) begin
            if (i_invalid) begin
              m_rsp_status <= STAT_INVALID;
            end else if (i_error) begin
              m_rsp_status <= STAT_ERROR;
            end else begin
              m_rsp_status <= STAT_OK;
            end
            m_rsp_rdata <= (!i_invalid && !i_error && head_read) ? i_rdata : '0;
            o_clear     <= 1'b1;
            state       <= ST_CLEAR;
          end else if (tmo_cnt == TMO_LAST) begin
            m_rsp_status <= STAT_TIMEOUT;
            m_rsp_rdata  <= '0;
            o_clear      <= 1'b1;
            state        <= ST_CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        ST_CLEAR: begin
          o_clear     <= 1'b0;
          m_rsp_tag   <= head_tag;
          m_rsp_valid <= 1'b1;
          state       <= ST_RESP;
        end

        ST_RESP: begin
          if (m_rsp_ready) begin
            m_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_axi_cmd_sequencer.sv
// tb/tb_simple_axi_cmd_sequencer.sv - self-checking bench for simple_axi_cmd_sequencer
module tb_simple_axi_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 20;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             s_cmd_valid = 1'b0;
  logic             s_cmd_ready;
  logic             s_cmd_read = 1'b0;
  logic [2:0]       s_cmd_size = '0;
  logic [31:0]      s_cmd_addr = '0;
  logic [63:0]      s_cmd_wdata = '0;
  logic [TAG_W-1:0] s_cmd_tag = '0;
  logic             m_rsp_valid;
  logic             m_rsp_ready = 1'b0;
  logic [63:0]      m_rsp_rdata;
  logic [TAG_W-1:0] m_rsp_tag;
  logic [1:0]       m_rsp_status;
  logic [2:0]       o_size;
  logic [31:0]      o_addr;
  logic [63:0]      o_wdata;
  logic [1:0]       o_rw;
  logic             o_clear;
  logic [63:0]      i_rdata = '0;
  logic             i_wait = 1'b0;
  logic             i_done = 1'b0;
  logic             i_error = 1'b0;
  logic             i_invalid = 1'b0;
  logic             o_busy;

  simple_axi_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .s_cmd_read   (s_cmd_read),
    .s_cmd_size   (s_cmd_size),
    .s_cmd_addr   (s_cmd_addr),
    .s_cmd_wdata  (s_cmd_wdata),
    .s_cmd_tag    (s_cmd_tag),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_ready  (m_rsp_ready),
    .m_rsp_rdata  (m_rsp_rdata),
    .m_rsp_tag    (m_rsp_tag),
    .m_rsp_status (m_rsp_status),
    .o_size       (o_size),
    .o_addr       (o_addr),
    .o_wdata      (o_wdata),
    .o_rw         (o_rw),
    .o_clear      (o_clear),
    .i_rdata      (i_rdata),
    .i_wait       (i_wait),
    .i_done       (i_done),
    .i_error      (i_error),
    .i_invalid    (i_invalid),
    .o_busy       (o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  // kind: 0 done, 1 error, 2 master-invalid, 3 never completes
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [1:0]       status;
    logic [63:0]      rdata;
  } rsp_t;

  typedef struct {
    logic        read;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          kind;
    int          lat;
    logic [63:0] rdata;
  } mcmd_t;

  rsp_t  exp_q[$];
  mcmd_t mst_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rw_cycles = 0;
  int clear_pulses = 0;
  int rsp_count = 0;
  int last_rw_fall = 0;
  int last_clear = 0;

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  // Reference: outcome of a command from its fields and the master behaviour.
  task automatic push_cmd(input logic rd, input logic [2:0] sz, input logic [31:0] ad,
                          input logic [63:0] wd, input logic [TAG_W-1:0] tg,
                          input int kind, input int lat, input logic [63:0] rdv);
    rsp_t  e;
    mcmd_t m;
    bit    legal;
    int    budget;
    legal = (sz <= 3'd3) && ((ad % (32'd1 << sz)) == 32'd0);
    e.tag = tg;
    e.rdata = 64'd0;
    if (!legal) e.status = 2'b10;
    else if (kind == 0) begin
      e.status = 2'b00;
      if (rd) e.rdata = rdv;
    end
    else if (kind == 1) e.status = 2'b01;
    else if (kind == 2) e.status = 2'b10;
    else e.status = 2'b11;
    m.read = rd; m.size = sz; m.addr = ad; m.wdata = wd;
    m.kind = kind; m.lat = lat; m.rdata = rdv;
    s_cmd_valid = 1'b1;
    s_cmd_read = rd; s_cmd_size = sz; s_cmd_addr = ad; s_cmd_wdata = wd; s_cmd_tag = tg;
    budget = 500;
    while (!s_cmd_ready && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (!s_cmd_ready) begin
      bad++;
      $display("FAIL push_accept tag=%0d ready=%0b want=1 within budget", tg, s_cmd_ready);
      s_cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    if (legal) mst_q.push_back(m);
    tick();
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget = 3000;
    while ((exp_q.size() != 0 || o_busy || m_rsp_valid) && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d busy=%0b want pending=0 busy=0", name, exp_q.size(), o_busy);
    end
  endtask

  // Master model: accepts on o_rw, raises i_wait, completes after lat cycles,
  // holds its flag until o_clear.
  initial begin : master
    int    mst;
    int    cnt;
    mcmd_t cur;
    mst = 0;
    cnt = 0;
    forever begin
      tick();
      if (i_rst || o_clear) begin
        i_wait = 0; i_done = 0; i_error = 0; i_invalid = 0;
        mst = 0;
      end else if (mst == 0) begin
        if (o_rw != 2'b00) begin
          if (mst_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_issue o_rw=%0d want no issue", o_rw);
          end else begin
            cur = mst_q.pop_front();
            total += 4;
            if (o_rw !== (cur.read ? 2'b10 : 2'b01)) begin
              bad++; $display("FAIL issue_rw got=%0d want=%0d", o_rw, cur.read ? 2 : 1);
            end
            if (o_addr !== cur.addr) begin
              bad++; $display("FAIL issue_addr got=%h want=%h", o_addr, cur.addr);
            end
            if (o_size !== cur.size) begin
              bad++; $display("FAIL issue_size got=%0d want=%0d", o_size, cur.size);
            end
            if (o_wdata !== cur.wdata) begin
              bad++; $display("FAIL issue_wdata got=%h want=%h", o_wdata, cur.wdata);
            end
            i_wait = 1'b1;
            cnt = 0;
            mst = 1;
          end
        end
      end else if (mst == 1) begin
        if (cur.kind != 3 && cnt >= cur.lat) begin
          i_done    = (cur.kind == 0);
          i_error   = (cur.kind == 1);
          i_invalid = (cur.kind == 2);
          i_rdata   = (cur.kind == 0 && cur.read) ? cur.rdata : {$urandom, $urandom};
          mst = 2;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: response scoreboard, o_rw/o_clear activity, pulse width.
  initial begin : monitor
    logic       prev_clear;
    logic [1:0] prev_rw;
    rsp_t       e;
    prev_clear = 1'b0;
    prev_rw = 2'b00;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (i_rst) begin
        prev_clear = 1'b0;
        prev_rw = 2'b00;
      end else begin
        if (o_rw != 2'b00) rw_cycles++;
        if (prev_rw != 2'b00 && o_rw == 2'b00) last_rw_fall = cyc;
        if (o_clear) begin
          clear_pulses++;
          last_clear = cyc;
          total++;
          if (prev_clear) begin
            bad++; $display("FAIL clear_width got=2+ cycles want=1");
          end
        end
        if (m_rsp_valid && m_rsp_ready) begin
          rsp_count++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp tag=%0d status=%0d", m_rsp_tag, m_rsp_status);
          end else begin
            e = exp_q.pop_front();
            total += 3;
            if (m_rsp_tag !== e.tag) begin
              bad++; $display("FAIL rsp_tag got=%0d want=%0d", m_rsp_tag, e.tag);
            end
            if (m_rsp_status !== e.status) begin
              bad++; $display("FAIL rsp_status tag=%0d got=%0d want=%0d", e.tag, m_rsp_status, e.status);
            end
            if (m_rsp_rdata !== e.rdata) begin
              bad++; $display("FAIL rsp_rdata tag=%0d got=%h want=%h", e.tag, m_rsp_rdata, e.rdata);
            end
          end
        end
        prev_clear = o_clear;
        prev_rw = o_rw;
      end
    end
  end

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    total += 3;
    if (s_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%0b want=1", s_cmd_ready);
    end
    if ({o_rw, o_clear, m_rsp_valid, o_busy, m_rsp_status, o_size} !== 10'd0) begin
      bad++; $display("FAIL reset_ctrl rw=%0d clr=%0b vld=%0b busy=%0b st=%0d sz=%0d want all 0",
                      o_rw, o_clear, m_rsp_valid, o_busy, m_rsp_status, o_size);
    end
    if ({m_rsp_rdata, m_rsp_tag, o_addr, o_wdata} !== '0) begin
      bad++; $display("FAIL reset_data rdata=%h tag=%0d addr=%h wdata=%h want 0",
                      m_rsp_rdata, m_rsp_tag, o_addr, o_wdata);
    end
    i_rst = 1'b0;
    tick();
    total++;
    if (s_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL post_reset ready=%0b busy=%0b want ready=1 busy=0", s_cmd_ready, o_busy);
    end
  endtask

  task automatic test_write();
    int rw0 = rw_cycles, cl0 = clear_pulses, rs0 = rsp_count;
    m_rsp_ready = 1'b1;
    push_cmd(1'b0, 3'd2, 32'h1000, 64'hDEADBEEF, 4'd3, 0, 4, 64'd0);
    wait_idle("write");
    total++;
    if (rw_cycles - rw0 != 1 || clear_pulses - cl0 != 1 || rsp_count - rs0 != 1) begin
      bad++; $display("FAIL write_counts rw=%0d clr=%0d rsp=%0d want 1/1/1",
                      rw_cycles - rw0, clear_pulses - cl0, rsp_count - rs0);
    end
  endtask

  task automatic test_read();
    int rw0 = rw_cycles, cl0 = clear_pulses;
    m_rsp_ready = 1'b1;
    push_cmd(1'b1, 3'd3, 32'h2008, 64'd0, 4'd5, 0, 2, 64'h0123456789ABCDEF);
    wait_idle("read");
    total++;
    if (rw_cycles - rw0 != 1 || clear_pulses - cl0 != 1) begin
      bad++; $display("FAIL read_counts rw=%0d clr=%0d want 1/1", rw_cycles - rw0, clear_pulses - cl0);
    end
  endtask

  task automatic test_misaligned();
    int rw0 = rw_cycles, cl0 = clear_pulses, rs0 = rsp_count;
    m_rsp_ready = 1'b1;
    push_cmd(1'b0, 3'd2, 32'h1002, 64'h11, 4'd7, 0, 1, 64'd0);
    push_cmd(1'b1, 3'd5, 32'h0000, 64'h22, 4'd8, 0, 1, 64'h99);
    push_cmd(1'b1, 3'd1, 32'h3002, 64'h33, 4'd9, 1, 1, 64'h77);
    push_cmd(1'b1, 3'd0, 32'h3003, 64'h44, 4'd10, 0, 0, 64'hA5A5);
    wait_idle("misaligned");
    total++;
    if (rw_cycles - rw0 != 2 || clear_pulses - cl0 != 2 || rsp_count - rs0 != 4) begin
      bad++; $display("FAIL misaligned_counts rw=%0d clr=%0d rsp=%0d want 2/2/4",
                      rw_cycles - rw0, clear_pulses - cl0, rsp_count - rs0);
    end
  endtask

  task automatic test_timeout();
    int cl0 = clear_pulses;
    m_rsp_ready = 1'b1;
    push_cmd(1'b0, 3'd0, 32'h55, 64'h1234, 4'd2, 3, 0, 64'd0);
    wait_idle("timeout");
    total += 2;
    if (last_clear - last_rw_fall != TIMEOUT) begin
      bad++; $display("FAIL timeout_delay got=%0d want=%0d", last_clear - last_rw_fall, TIMEOUT);
    end
    if (clear_pulses - cl0 != 1) begin
      bad++; $display("FAIL timeout_clear got=%0d want=1", clear_pulses - cl0);
    end
  endtask

  task automatic test_fill();
    int rs0 = rsp_count;
    m_rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_cmd(1'b1, 3'd2, 32'h100 + 32'(i * 4), 64'(i), TAG_W'(i), 0, (i == 0) ? 10 : 1,
               64'hF00D_0000 + 64'(i));
    end
    total++;
    if (s_cmd_ready !== 1'b0) begin
      bad++; $display("FAIL fill_ready got=%0b want=0", s_cmd_ready);
    end
    push_cmd(1'b0, 3'd3, 32'h200, 64'hCAFE, TAG_W'(DEPTH), 0, 1, 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (m_rsp_valid !== 1'b1 || m_rsp_tag !== '0 || s_cmd_ready !== 1'b0) begin
        bad++; $display("FAIL fill_hold vld=%0b tag=%0d ready=%0b want 1/0/0",
                        m_rsp_valid, m_rsp_tag, s_cmd_ready);
      end
    end
    m_rsp_ready = 1'b1;
    wait_idle("fill");
    total++;
    if (rsp_count - rs0 != DEPTH + 1) begin
      bad++; $display("FAIL fill_rsp_count got=%0d want=%0d", rsp_count - rs0, DEPTH + 1);
    end
  endtask

  task automatic test_reset_mid();
    int budget = 200;
    m_rsp_ready = 1'b1;
    push_cmd(1'b1, 3'd3, 32'h40, 64'd0, 4'd6, 3, 0, 64'd0);
    push_cmd(1'b0, 3'd2, 32'h44, 64'h5, 4'd7, 0, 1, 64'd0);
    while (o_rw == 2'b00 && budget > 0) begin tick(); budget--; end
    while (o_rw != 2'b00 && budget > 0) begin tick(); budget--; end
    total++;
    if (budget == 0) begin
      bad++; $display("FAIL reach_wait rw=%0d want issue then idle", o_rw);
    end
    tick();
    tick();
    i_rst = 1'b1;
    #1;
    total += 2;
    if (o_rw !== 2'b00 || m_rsp_valid !== 1'b0 || o_clear !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl rw=%0d vld=%0b clr=%0b want 0", o_rw, m_rsp_valid, o_clear);
    end
    if (s_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL midrst_fifo ready=%0b busy=%0b want 1/0", s_cmd_ready, o_busy);
    end
    exp_q.delete();
    mst_q.delete();
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit stop = 0;
    int rs0 = rsp_count;
    int n = 40;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [2:0]  sz;
          logic [31:0] ad;
          int          kr;
          int          kind;
          repeat ($urandom_range(0, 3)) tick();
          sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
          ad = $urandom;
          if ($urandom_range(0, 3) != 0) ad = ad & ~32'h7;
          kr = $urandom_range(0, 9);
          kind = (kr <= 5) ? 0 : (kr - 6);
          push_cmd(1'($urandom_range(0, 1)), sz, ad, {$urandom, $urandom}, TAG_W'($urandom),
                   kind, $urandom_range(0, 5), {$urandom, $urandom});
        end
        wait_idle("random");
        stop = 1;
      end
      begin
        while (!stop) begin
          m_rsp_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    m_rsp_ready = 1'b1;
    total++;
    if (rsp_count - rs0 != n) begin
      bad++; $display("FAIL random_rsp_count got=%0d want=%0d", rsp_count - rs0, n);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_misaligned();
    test_timeout();
    test_fill();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
